morse_symbolizer: RTL
=====================

MORSE_SYMBOLIZER -- requirements
Module: morse_symbolizer

Interface
REQ-001 Parameter UNIT, default 1, clock cycles per Morse time unit (dot length); legal range 1..51.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..3.
REQ-003 Parameter CNT_W, default 8, run-length counter width; 5*UNIT SHALL fit in CNT_W bits.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in  in  1  raw keyed Morse level (1 = mark, 0 = space), asynchronous to clk.
REQ-007 sym_valid  out  1  a symbol is held on sym.
REQ-008 sym_ready  in  1  downstream decoder accepts the symbol.
REQ-009 sym  out  2  00 DOT, 01 DASH, 10 CHAR_END, 11 WORD_END.
REQ-010 overflow  out  1  sticky, set when a symbol is lost.

Function
REQ-011 in SHALL pass through a SYNC_STAGES-flop synchronizer; the FSM SHALL use only the synchronized level s.
REQ-012 A run counter cnt SHALL count consecutive cycles of equal s, reload to 1 on any change of s, and saturate at all-ones.
REQ-013 States: IDLE, MARK, SPACE, CGAP; reset state IDLE.
REQ-014 IDLE: s=1 -> MARK, cnt=1; s=0 -> stay, emit nothing, so leading space never produces a symbol.
REQ-015 MARK: s=0 -> emit DOT if cnt < 2*UNIT, else DASH; go to SPACE, cnt=1.
REQ-016 SPACE: s=1 -> MARK; cnt reaching 2*UNIT -> emit CHAR_END, go to CGAP, counting continues.
REQ-017 CGAP: s=1 -> MARK; cnt reaching 5*UNIT -> emit WORD_END, go to IDLE.
REQ-018 CHAR_END and WORD_END SHALL each be emitted at most once per gap; a mark that saturates cnt SHALL still classify as DASH.
REQ-019 An emitted symbol SHALL appear on sym with sym_valid=1 from the edge on which the FSM transition occurs, i.e. valid is high after the (SYNC_STAGES+1)-th rising edge, counting the edge that first samples the changed in.
REQ-020 sym and sym_valid SHALL hold stable until a cycle with sym_valid=1 and sym_ready=1; sym_valid drops on the next edge unless a new symbol is emitted in that same cycle.
REQ-021 Emission in the acceptance cycle: the new symbol SHALL load and sym_valid SHALL stay 1, with no loss.
REQ-022 Emission while sym_valid=1 and sym_ready=0: the new symbol SHALL be dropped, the held symbol kept, and overflow set to 1.
REQ-023 overflow SHALL clear only on reset.
REQ-024 sym_ready SHALL have no effect while sym_valid=0.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, synchronizer flops=0, sym_valid=0, sym=00, overflow=0.
REQ-026 Reset asserted mid-mark or mid-gap SHALL discard the partial symbol; after release, the first symbol SHALL come only from a complete new mark.
REQ-027 Reset release SHALL be synchronized externally; the block SHALL not require a minimum reset pulse longer than one clk period.

Structure
REQ-028 Package morse_pkg SHALL hold the sym_t enum (DOT, DASH, CHAR_END, WORD_END) and the state_t enum.
REQ-029 Sub-module morse_sync SHALL implement the SYNC_STAGES flop chain with async active-low reset; the rest is in one module.

Verification (UNIT=1, SYNC_STAGES=2 unless stated)
REQ-030 in=1 for 1 cycle, then 0 for 10 cycles, sym_ready=1 -> DOT 3 edges after the first in=0 sample, then CHAR_END, then WORD_END, each a 1-cycle pulse, and nothing after.
REQ-031 Letter "A" (1,0,1,1,1,0,0,0...), sym_ready=1 -> DOT, DASH, CHAR_END, WORD_END, in that order, and overflow=0.
REQ-032 UNIT=3: mark of 5 cycles -> DOT; mark of 6 cycles -> DASH; space of 5 cycles -> no CHAR_END; space of 6 -> CHAR_END.
REQ-033 sym_ready=0 throughout "A" -> sym holds DOT, overflow=1 after the DASH emission; then sym_ready=1 -> DOT is accepted and sym_valid falls.
REQ-034 rst_n pulsed low in the middle of a 3-cycle mark -> all outputs 0 immediately; the remaining mark cycles after release produce no symbol until a fresh 0->1->0.
REQ-035 Mark held for 300 cycles with CNT_W=8 -> cnt saturates at 255 and exactly one DASH is emitted.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types for the Morse symbolizer: symbol codes on the output channel
// and the FSM state encoding.
package morse_pkg;

    typedef enum logic [1:0] {
        DOT      = 2'b00,
        DASH     = 2'b01,
        CHAR_END = 2'b10,
        WORD_END = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        CGAP
    } state_t;

endpackage

// File: rtl/morse_sync.sv
// Multi-flop synchronizer bringing the asynchronous keyed level into the clk domain.
module morse_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/morse_symbolizer.sv
// Classifies synchronized mark/space run lengths into DOT/DASH/CHAR_END/WORD_END
// symbols and offers them on a valid/ready channel with a sticky loss flag.
module morse_symbolizer
    import morse_pkg::*;
#(
    parameter int UNIT        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(2 * UNIT);
    localparam logic [CNT_W-1:0] WORD_MIN  = CNT_W'(5 * UNIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [1:0]       FILL_DONE = 2'(SYNC_STAGES);

    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic             emit;
    sym_t             emit_sym;
    sym_t             sym_q;
    logic             sym_valid_q;
    logic             overflow_q;

    morse_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (in),
        .q_o   (s)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_sym = DOT;

        // The previous level of s is implied by the state: only MARK follows a 1.
        if (s != (state_q == MARK)) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (s && armed_q) state_d = MARK;
            end
            MARK: begin
                if (!s) begin
                    emit     = 1'b1;
                    emit_sym = (cnt_q < DASH_MIN) ? DOT : DASH;
                    state_d  = SPACE;
                end
            end
            SPACE: begin
                if (s) begin
                    state_d = MARK;
                end else if (cnt_d == DASH_MIN) begin
                    emit     = 1'b1;
                    emit_sym = CHAR_END;
                    state_d  = CGAP;
                end
            end
            CGAP: begin
                if (s) begin
                    state_d = MARK;
                end else if (cnt_d >= WORD_MIN) begin
                    emit     = 1'b1;
                    emit_sym = WORD_END;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A mark may only start once a genuine post-reset space has passed through the
    // synchronizer, so a mark cut by reset never yields a symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_q       <= DOT;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (fill_q != FILL_DONE) begin
                fill_q <= fill_q + 2'd1;
            end else if (!s) begin
                armed_q <= 1'b1;
            end

            if (emit) begin
                if (!sym_valid_q || sym_ready) begin
                    sym_q       <= emit_sym;
                    sym_valid_q <= 1'b1;
                end else begin
                    overflow_q  <= 1'b1;
                end
            end else if (sym_ready) begin
                sym_valid_q <= 1'b0;
            end
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign overflow  = overflow_q;

endmodule
